spi_master_gen: RTL and testbench

SPI_MASTER_GEN -- requirements
Module: spi_master_gen

---
 rtl/spi_master_gen.sv | 230 +++++++++++++++++++++++
 tb/tb_spi_master_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_gen
// Desc     : Multi-frame SPI master with CPOL/CPHA and chip-select decode.
//            Define SPI_MASTER_LSB_FIRST_EN to add the lsb_first_i port.
// Revision : 1.0
// ============================================================================
module spi_master_gen #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int N_CS    = 2,
  parameter int F_MAX   = 4,
  localparam int CS_W   = (N_CS > 1) ? $clog2(N_CS) : 1,
  localparam int FR_W   = $clog2(F_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic [CS_W-1:0]   cs_sel_i,
  input  logic [FR_W-1:0]   frames_i,
  input  logic [DATA_W-1:0] tx_data_i,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsb_first_i,
`endif
  output logic              tx_req_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [N_CS-1:0]   CS
);

  localparam int CNT_W  = 8;
  localparam int EDGE_W = $clog2(2 * DATA_W);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_setup = 3'd1;
  localparam logic [2:0] c_st_xfer  = 3'd2;
  localparam logic [2:0] c_st_gap   = 3'd3;
  localparam logic [2:0] c_st_hold  = 3'd4;

  localparam logic [CNT_W-1:0]  c_cnt_last  = CNT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] c_edge_last = EDGE_W'(2 * DATA_W - 1);
  localparam logic [EDGE_W-1:0] c_edge_pre  = EDGE_W'(2 * DATA_W - 2);
  localparam logic [FR_W-1:0]   c_fmax      = FR_W'(F_MAX);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [EDGE_W-1:0] r_edge;
  logic [FR_W-1:0]   r_frames_left;
  logic              r_cpha;
  logic [DATA_W-1:0] r_tx_shift;
  logic [DATA_W-1:0] r_rx_shift;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_tx_req;
  logic              r_rx_valid;
  logic              r_busy;
  logic              r_done;
  logic [N_CS-1:0]   r_cs;

  logic              w_lsb;
  logic              w_accept;
  logic              w_tick;
  logic              w_edge_last;
  logic              w_lead;
  logic              w_do_shift;
  logic              w_do_sample;
  logic              w_sample_last;
  logic [FR_W-1:0]   w_frames_eff;
  logic [DATA_W-1:0] w_rx_next;

`ifdef SPI_MASTER_LSB_FIRST_EN
  logic r_lsb;
  assign w_lsb = r_lsb;
`else
  assign w_lsb = 1'b0;
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] word, input logic lsb);
    return lsb ? word[0] : word[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] word, input logic lsb);
    return lsb ? {1'b0, word[DATA_W-1:1]} : {word[DATA_W-2:0], 1'b0};
  endfunction

  assign w_accept    = (r_state == c_st_idle) && start_i && (32'(cs_sel_i) < 32'(N_CS));
  assign w_tick      = (r_cnt == c_cnt_last);
  assign w_edge_last = (r_edge == c_edge_last);
  // Even edge indices are leading edges, odd ones trailing.
  assign w_lead        = ~r_edge[0];
  assign w_do_shift    = r_cpha ? w_lead : (~w_lead && ~w_edge_last);
  assign w_do_sample   = r_cpha ? ~w_lead : w_lead;
  assign w_sample_last = r_cpha ? w_edge_last : (r_edge == c_edge_pre);
  assign w_rx_next     = w_lsb ? {MISO, r_rx_shift[DATA_W-1:1]} : {r_rx_shift[DATA_W-2:0], MISO};

  always_comb begin
    w_frames_eff = frames_i;
    if (frames_i == '0) begin
      w_frames_eff = FR_W'(1);
    end else if (frames_i > c_fmax) begin
      w_frames_eff = c_fmax;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_st_idle;
      r_cnt         <= '0;
      r_edge        <= '0;
      r_frames_left <= '0;
      r_cpha        <= 1'b0;
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_sclk        <= 1'b0;
      r_mosi        <= 1'b0;
      r_tx_req      <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cs          <= '1;
`ifdef SPI_MASTER_LSB_FIRST_EN
      r_lsb         <= 1'b0;
`endif
    end else begin
      r_tx_req   <= 1'b0;
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
      if (r_state == c_st_idle || w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_state       <= c_st_setup;
            r_cpha        <= cpha_i;
            r_sclk        <= cpol_i;
            r_frames_left <= w_frames_eff - FR_W'(1);
            r_tx_shift    <= tx_data_i;
            r_tx_req      <= 1'b1;
            r_busy        <= 1'b1;
            r_cs          <= ~(N_CS'(1) << cs_sel_i);
`ifdef SPI_MASTER_LSB_FIRST_EN
            r_lsb         <= lsb_first_i;
`endif
          end
        end
        c_st_setup: begin
          if (w_tick) begin
            r_state <= c_st_xfer;
            r_edge  <= '0;
            if (!r_cpha) begin
              r_mosi     <= first_bit(r_tx_shift, w_lsb);
              r_tx_shift <= shift_word(r_tx_shift, w_lsb);
            end
          end
        end
        c_st_xfer: begin
          if (w_tick) begin
            r_sclk <= ~r_sclk;
            r_edge <= r_edge + 1'b1;
            if (w_do_shift) begin
              r_mosi     <= first_bit(r_tx_shift, w_lsb);
              r_tx_shift <= shift_word(r_tx_shift, w_lsb);
            end
            if (w_do_sample) begin
              r_rx_shift <= w_rx_next;
              if (w_sample_last) begin
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
              end
            end
            if (w_edge_last) begin
              if (r_frames_left != '0) begin
                r_state       <= c_st_gap;
                r_frames_left <= r_frames_left - 1'b1;
              end else begin
                r_state <= c_st_hold;
              end
            end
          end
        end
        c_st_gap: begin
          // The next word is captured here so CPHA=0 can present its first bit at once.
          if (w_tick) begin
            r_state  <= c_st_xfer;
            r_edge   <= '0;
            r_tx_req <= 1'b1;
            if (!r_cpha) begin
              r_mosi     <= first_bit(tx_data_i, w_lsb);
              r_tx_shift <= shift_word(tx_data_i, w_lsb);
            end else begin
              r_tx_shift <= tx_data_i;
            end
          end
        end
        c_st_hold: begin
          if (w_tick) begin
            r_state <= c_st_idle;
            r_cs    <= '1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign tx_req_o   = r_tx_req;
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign SCLK       = r_sclk;
  assign MOSI       = r_mosi;
  assign CS         = r_cs;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_gen
// Desc     : Scoreboard bench for spi_master_gen (CLK_DIV=2 and CLK_DIV=1 builds).
// Revision : 1.0
// ============================================================================
module tb_spi_master_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: DATA_W=8, CLK_DIV=2, N_CS=3, F_MAX=4
  logic       start_i, cpol_i, cpha_i;
  logic [1:0] cs_sel_i;
  logic [2:0] frames_i;
  logic [7:0] tx_data_i;
  logic       tx_req_o, rx_valid_o, busy_o, done_o, sclk, mosi, miso;
  logic [7:0] rx_data_o;
  logic [2:0] cs;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic       lsb_first_i;
`endif

  // DUT B: DATA_W=8, CLK_DIV=1, N_CS=2, F_MAX=4
  logic       b_start, b_tx_req, b_rx_valid, b_busy, b_done, b_sclk, b_mosi;
  logic [2:0] b_frames;
  logic [7:0] b_tx, b_rx;
  logic [1:0] b_cs;

  int         miso_mode;
  logic [7:0] words [4];
  int         tx_base;
  int         tx_reqs, rx_cnt, done_cnt, cs_glitch;
  int         b_rx_cnt, b_tcyc;
  int         cyc;
  int         n_tests, n_fail;
  logic       prev_busy, prev_sclk, b_prev_busy, b_prev_sclk;
  logic       mosi_q [$];
  int         b_rise_q [$];
  logic [7:0] exp_rx [$];
  logic [7:0] exp_b [$];

  assign miso      = (miso_mode == 0) ? mosi : ((miso_mode == 1) ? 1'b1 : 1'b0);
  assign tx_data_i = ((tx_reqs - tx_base) < 4) ? words[2'(tx_reqs - tx_base)] : 8'h00;

  spi_master_gen #(.DATA_W(8), .CLK_DIV(2), .N_CS(3), .F_MAX(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
    .cs_sel_i(cs_sel_i), .frames_i(frames_i), .tx_data_i(tx_data_i),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first_i(lsb_first_i),
`endif
    .tx_req_o(tx_req_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .busy_o(busy_o), .done_o(done_o), .SCLK(sclk), .MOSI(mosi), .MISO(miso), .CS(cs)
  );

  spi_master_gen #(.DATA_W(8), .CLK_DIV(1), .N_CS(2), .F_MAX(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(b_start), .cpol_i(1'b0), .cpha_i(1'b0),
    .cs_sel_i(1'b0), .frames_i(b_frames), .tx_data_i(b_tx),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first_i(1'b0),
`endif
    .tx_req_o(b_tx_req), .rx_data_o(b_rx), .rx_valid_o(b_rx_valid),
    .busy_o(b_busy), .done_o(b_done), .SCLK(b_sclk), .MOSI(b_mosi), .MISO(b_mosi), .CS(b_cs)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_bits(input int base, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], mosi_q[base + i]};
    return v;
  endfunction

  // Monitor A: counts pulses, records MOSI at rising SCLK, pops the rx scoreboard.
  initial begin
    logic [7:0] e;
    prev_busy = 1'b0;
    prev_sclk = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_req_o) tx_reqs++;
      if (done_o) done_cnt++;
      if (busy_o && cs !== 3'b110) cs_glitch++;
      if (busy_o && prev_busy && sclk && !prev_sclk) mosi_q.push_back(mosi);
      if (rx_valid_o) begin
        rx_cnt++;
        if (exp_rx.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_unexpected: got %0h, expected no word", rx_data_o);
        end else begin
          e = exp_rx.pop_front();
          check("rx_data", 32'(rx_data_o), 32'(e));
        end
      end
      prev_busy = busy_o;
      prev_sclk = sclk;
    end
  end

  // Monitor B
  initial begin
    logic [7:0] e;
    b_prev_busy = 1'b0;
    b_prev_sclk = 1'b0;
    forever begin
      @(negedge clk);
      b_tcyc++;
      if (b_busy && b_prev_busy && b_sclk && !b_prev_sclk) b_rise_q.push_back(b_tcyc);
      if (b_rx_valid) begin
        b_rx_cnt++;
        if (exp_b.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL b_rx_unexpected: got %0h, expected no word", b_rx);
        end else begin
          e = exp_b.pop_front();
          check("b_rx_data", 32'(b_rx), 32'(e));
        end
      end
      b_prev_busy = b_busy;
      b_prev_sclk = b_sclk;
    end
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_txn(input logic pol, input logic pha, input logic [2:0] fr);
    @(negedge clk);
    cpol_i   = pol;
    cpha_i   = pha;
    cs_sel_i = 2'd0;
    frames_i = fr;
    tx_base  = tx_reqs;
    start_i  = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    cyc      = 0;
  endtask

  task automatic wait_done(input string name, input int exp_cyc);
    while (!done_o && cyc < 1000) step();
    check(name, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    int m0, r0, t0, d0;
    rst_n = 1'b0; start_i = 1'b0; cpol_i = 1'b0; cpha_i = 1'b0; cs_sel_i = 2'd0;
    frames_i = 3'd1; miso_mode = 0; tx_base = 0;
    b_start = 1'b0; b_frames = 3'd0; b_tx = 8'h00;
    words[0] = 8'h00; words[1] = 8'h00; words[2] = 8'h00; words[3] = 8'h00;
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_first_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs), 32'h7);
    check("rst_sclk_mosi", 32'({sclk, mosi}), 32'h0);
    check("rst_rx_data", 32'(rx_data_o), 32'h0);
    check("rst_flags", 32'({tx_req_o, rx_valid_o, busy_o, done_o}), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0, one frame, loopback
    words[0] = 8'hA5; miso_mode = 0; exp_rx.push_back(8'hA5);
    m0 = mosi_q.size(); r0 = rx_cnt;
    start_txn(1'b0, 1'b0, 3'd1);
    check("t1_busy", 32'(busy_o), 32'h1);
    check("t1_cs", 32'(cs), 32'h6);
    wait_done("t1_done_cycles", 36);
    repeat (2) @(negedge clk);
    check("t1_sclk_rises", 32'(mosi_q.size() - m0), 32'd8);
    check("t1_mosi_bits", pack_bits(m0, 8), 32'hA5);
    check("t1_rx_pulses", 32'(rx_cnt - r0), 32'd1);

    // Mode 3, three frames, MISO tied high
    words[0] = 8'hAA; words[1] = 8'h55; words[2] = 8'h5D; miso_mode = 1;
    repeat (3) exp_rx.push_back(8'hFF);
    m0 = mosi_q.size(); r0 = rx_cnt; t0 = tx_reqs; cs_glitch = 0;
    start_txn(1'b1, 1'b1, 3'd3);
    wait_done("t2_done_cycles", 104);
    repeat (2) @(negedge clk);
    check("t2_tx_req_pulses", 32'(tx_reqs - t0), 32'd3);
    check("t2_rx_pulses", 32'(rx_cnt - r0), 32'd3);
    check("t2_sclk_rises", 32'(mosi_q.size() - m0), 32'd24);
    check("t2_mosi_bits", pack_bits(m0, 24), 32'hAA555D);
    check("t2_cs_glitches", 32'(cs_glitch), 32'd0);
    check("t2_sclk_idle", 32'(sclk), 32'h1);

    // Start while busy and start with out-of-range select are both ignored
    words[0] = 8'h3C; miso_mode = 0; exp_rx.push_back(8'h3C);
    start_txn(1'b0, 1'b0, 3'd1);
    repeat (9) step();
    cs_sel_i = 2'd2; start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("t3_busy_cs", 32'(cs), 32'h6);
    check("t3_busy_kept", 32'(busy_o), 32'h1);
    wait_done("t3_done_cycles", 36);
    t0 = tx_reqs;
    @(negedge clk); cs_sel_i = 2'd3; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_badsel_busy", 32'(busy_o), 32'h0);
    check("t3_badsel_cs", 32'(cs), 32'h7);
    check("t3_badsel_txreq", 32'(tx_reqs - t0), 32'd0);

    // frames_i above F_MAX clamps to four frames
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    exp_rx.push_back(8'h11); exp_rx.push_back(8'h22); exp_rx.push_back(8'h33); exp_rx.push_back(8'h44);
    r0 = rx_cnt; t0 = tx_reqs;
    start_txn(1'b0, 1'b0, 3'd7);
    wait_done("t4_done_cycles", 138);
    repeat (2) @(negedge clk);
    check("t4_rx_pulses", 32'(rx_cnt - r0), 32'd4);
    check("t4_tx_req_pulses", 32'(tx_reqs - t0), 32'd4);

    // Asynchronous reset in the middle of frame 2 of 3
    words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h56; miso_mode = 2;
    exp_rx.push_back(8'h00);
    r0 = rx_cnt; d0 = done_cnt;
    start_txn(1'b0, 1'b0, 3'd3);
    while (rx_cnt == r0 && cyc < 500) step();
    repeat (12) step();
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_cs", 32'(cs), 32'h7);
    check("t5_rst_sclk", 32'(sclk), 32'h0);
    check("t5_rst_busy", 32'(busy_o), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_rx_pulses", 32'(rx_cnt - r0), 32'd1);
    check("t5_scoreboard_empty", 32'(exp_rx.size()), 32'd0);

    // DUT B: frames_i=0 with CLK_DIV=1
    b_tx = 8'h96; b_frames = 3'd0; exp_b.push_back(8'h96);
    r0 = b_rx_cnt; m0 = b_rise_q.size();
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0; cyc = 0;
    while (!b_done && cyc < 1000) step();
    check("b_done_cycles", 32'(cyc), 32'd18);
    repeat (2) @(negedge clk);
    check("b_rx_pulses", 32'(b_rx_cnt - r0), 32'd1);
    check("b_sclk_rises", 32'(b_rise_q.size() - m0), 32'd8);
    if (b_rise_q.size() >= m0 + 2) check("b_sclk_period", 32'(b_rise_q[m0 + 1] - b_rise_q[m0]), 32'd2);
    else check("b_sclk_period", 32'(b_rise_q.size() - m0), 32'd8);

`ifdef SPI_MASTER_LSB_FIRST_EN
    // LSB-first transmit and receive
    lsb_first_i = 1'b1; words[0] = 8'h01; miso_mode = 0; exp_rx.push_back(8'h01);
    m0 = mosi_q.size();
    start_txn(1'b0, 1'b0, 3'd1);
    wait_done("t7_done_cycles", 36);
    repeat (2) @(negedge clk);
    check("t7_mosi_bits", pack_bits(m0, 8), 32'h80);
    lsb_first_i = 1'b0;
`endif

    check("final_scoreboard_empty", 32'(exp_rx.size() + exp_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
